// File: rtl/led_irq_reg_if.sv
// Word-addressed register port of the LED interrupt aggregator.
// The bus master drives the strobes; the block returns registered read data.
interface led_irq_reg_if;
  logic        reg_wr_i;
  logic        reg_rd_i;
  logic [3:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_rvalid_o;

  modport master (output reg_wr_i, reg_rd_i, reg_addr_i, reg_wdata_i,
                  input  reg_rdata_o, reg_rvalid_o);
  modport slave  (input  reg_wr_i, reg_rd_i, reg_addr_i, reg_wdata_i,
                  output reg_rdata_o, reg_rvalid_o);
endinterface

// File: rtl/led_irq_ctrl.sv
// Interrupt aggregator for the LED counter channels: sticky pending bits,
// per-channel saturating event counters, masked level IRQ with hold-off.
module led_irq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             evt,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  // A clear coincident with an event leaves the new event counted.
  always_ff @(posedge clk100) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= CNT_W'(evt);
    else if (evt && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

module led_irq_ctrl #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 16,
  parameter int HOLDOFF_W = 16
) (
  input  logic           clk100,
  input  logic           rst,
  input  logic [NCH-1:0] evt_i,
  led_irq_reg_if.slave   bus,
  output logic           irq_o
);
  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

  state_t                          state;
  logic [NCH-1:0]                  pend, mask, cnt_clr;
  logic [HOLDOFF_W-1:0]            holdoff, timer;
  logic [NCH-1:0][CNT_W-1:0]       cnt;
  logic [NCH-1:0]                  w1c;
  logic [31:0]                     rd_mux;
  logic                            active;
  logic                            unused_wdata;

  assign unused_wdata = ^bus.reg_wdata_i;
  assign active       = |(pend & mask);
  assign w1c          = (bus.reg_wr_i && bus.reg_addr_i == 4'h0) ? bus.reg_wdata_i[NCH-1:0] : '0;

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      assign cnt_clr[i] = bus.reg_wr_i && bus.reg_addr_i == 4'(4 + i);
      led_irq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk100 (clk100),
        .rst    (rst),
        .evt    (evt_i[i]),
        .clr    (cnt_clr[i]),
        .cnt    (cnt[i])
      );
    end
  endgenerate

  // Set beats W1C so an event landing on a clear is never lost.
  always_ff @(posedge clk100) begin
    if (rst) begin
      pend    <= '0;
      mask    <= '0;
      holdoff <= '0;
    end else begin
      pend <= (pend & ~w1c) | evt_i;
      if (bus.reg_wr_i && bus.reg_addr_i == 4'h1) mask    <= bus.reg_wdata_i[NCH-1:0];
      if (bus.reg_wr_i && bus.reg_addr_i == 4'h2) holdoff <= bus.reg_wdata_i[HOLDOFF_W-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr_i)
      4'h0:    rd_mux[NCH-1:0]       = pend;
      4'h1:    rd_mux[NCH-1:0]       = mask;
      4'h2:    rd_mux[HOLDOFF_W-1:0] = holdoff;
      4'h3:    rd_mux[NCH-1:0]       = evt_i;
      default: begin
        for (int n = 0; n < NCH; n++)
          if (bus.reg_addr_i == 4'(4 + n)) rd_mux[CNT_W-1:0] = cnt[n];
      end
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      bus.reg_rdata_o  <= '0;
      bus.reg_rvalid_o <= 1'b0;
    end else begin
      bus.reg_rvalid_o <= bus.reg_rd_i;
      if (bus.reg_rd_i) bus.reg_rdata_o <= rd_mux;
    end
  end

  // Timer is latched from HOLDOFF on entry, so later writes leave it alone.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (active) begin
          state <= ASSERT;
          irq_o <= 1'b1;
        end
        ASSERT: if (!active) begin
          state <= HOLD;
          timer <= holdoff;
          irq_o <= 1'b0;
        end
        HOLD: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - 1'b1;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_irq_ctrl.sv
// Bench for led_irq_ctrl: directed scenarios then random traffic, checked
// against a cycle-level reference model through a read-data scoreboard.
module tb_led_irq_ctrl;
  localparam int NCH = 4, CNT_W = 4, HOLDOFF_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  logic [NCH-1:0] evt_i = '0;
  logic irq_o;
  led_irq_reg_if bus();

  led_irq_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF_W(HOLDOFF_W)) dut (
    .clk100 (clk100),
    .rst    (rst),
    .evt_i  (evt_i),
    .bus    (bus),
    .irq_o  (irq_o)
  );

  always #5 clk100 = ~clk100;

  int checks = 0, errors = 0;

  // Reference model: register contents as plain numbers, IRQ as a level
  // plus a count of forced-quiet cycles remaining after it drops.
  logic [NCH-1:0] m_pend = '0, m_mask = '0;
  int unsigned    m_hold = 0;
  int             m_cnt[NCH];
  bit             m_irq = 1'b0;
  int             m_quiet = 0;
  logic [31:0]    exp_q[$];

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 4'h0)      v = 32'(m_pend);
    else if (a == 4'h1) v = 32'(m_mask);
    else if (a == 4'h2) v = m_hold;
    else if (a == 4'h3) v = 32'(evt_i);
    else if (a >= 4 && int'(a) < 4 + NCH) v = m_cnt[int'(a) - 4];
    return v;
  endfunction

  task automatic model_step();
    bit active;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_hold = 0; m_irq = 0; m_quiet = 0;
      for (int n = 0; n < NCH; n++) m_cnt[n] = 0;
      return;
    end
    active = (m_pend & m_mask) != '0;
    if (bus.reg_rd_i) exp_q.push_back(model_read(bus.reg_addr_i));
    if (m_irq) begin
      if (!active) begin m_irq = 0; m_quiet = m_hold + 1; end
    end else if (m_quiet > 0) m_quiet--;
    else if (active) m_irq = 1;
    if (bus.reg_wr_i) begin
      case (bus.reg_addr_i)
        4'h0: m_pend = m_pend & ~bus.reg_wdata_i[NCH-1:0];
        4'h1: m_mask = bus.reg_wdata_i[NCH-1:0];
        4'h2: m_hold = bus.reg_wdata_i[HOLDOFF_W-1:0];
        default: if (bus.reg_addr_i >= 4 && int'(bus.reg_addr_i) < 4 + NCH)
                   m_cnt[int'(bus.reg_addr_i) - 4] = 0;
      endcase
    end
    m_pend = m_pend | evt_i;
    for (int n = 0; n < NCH; n++)
      if (evt_i[n] && m_cnt[n] < CNT_MAX) m_cnt[n]++;
  endtask

  initial begin
    for (int n = 0; n < NCH; n++) m_cnt[n] = 0;
    forever begin
      @(posedge clk100);
      model_step();
    end
  end

  // Monitor: every read must come back exactly one cycle later.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk100);
      checks++;
      if (irq_o !== m_irq) begin
        errors++;
        $display("FAIL irq t=%0t got %b want %b", $time, irq_o, m_irq);
      end
      if (bus.reg_rvalid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_spurious t=%0t rdata %h", $time, bus.reg_rdata_o);
        end else begin
          exp = exp_q.pop_front();
          if (bus.reg_rdata_o !== exp) begin
            errors++;
            $display("FAIL rdata t=%0t got %h want %h", $time, bus.reg_rdata_o, exp);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_missing t=%0t rvalid %b want 1", $time, bus.reg_rvalid_o);
        exp_q.delete();
      end
    end
  end

  task automatic cyc(input bit wr, input bit rd, input logic [3:0] a,
                     input logic [31:0] d, input logic [NCH-1:0] e);
    bus.reg_wr_i = wr; bus.reg_rd_i = rd; bus.reg_addr_i = a;
    bus.reg_wdata_i = d; evt_i = e;
    @(negedge clk100);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 4'h0, 32'h0, '0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(1, 0, a, d, '0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(0, 1, a, 32'h0, '0);
  endtask

  initial begin
    bus.reg_wr_i = 0; bus.reg_rd_i = 0; bus.reg_addr_i = '0; bus.reg_wdata_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk100);
    rst = 1'b0;

    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    // Basic raise and W1C drop
    wr(4'h1, 32'h1);
    cyc(0, 0, 4'h0, 32'h0, 4'h1);
    rd(4'h0);
    idle(2);
    wr(4'h0, 32'h1);
    idle(3);

    // Hold-off rate limiting, second event arrives during HOLD
    wr(4'h2, 32'd10);
    cyc(0, 0, 4'h0, 32'h0, 4'h1);
    idle(3);
    wr(4'h0, 32'h1);
    idle(1);
    cyc(0, 0, 4'h0, 32'h0, 4'h1);
    wr(4'h2, 32'd3);
    for (int k = 0; k < 14; k++) rd(4'h0);
    wr(4'h0, 32'hF);
    idle(16);

    // Event and W1C on the same bit; other bits still clear
    wr(4'h1, 32'hF);
    cyc(0, 0, 4'h0, 32'h0, 4'h1);
    cyc(1, 0, 4'h0, 32'h5, 4'h4);
    rd(4'h0);
    wr(4'h0, 32'hF);
    idle(8);

    // Counter saturation, clear coincident with event
    for (int k = 0; k < 20; k++) cyc(0, 0, 4'h0, 32'h0, 4'h2);
    rd(4'h5);
    cyc(1, 0, 4'h5, 32'hDEAD, 4'h2);
    rd(4'h5);
    rd(4'h3);
    cyc(0, 1, 4'h3, 32'h0, 4'hA);
    wr(4'h0, 32'hF);
    idle(8);

    // Masked pending, late MASK write, then reset mid-ASSERT
    wr(4'h1, 32'h0);
    cyc(0, 0, 4'h0, 32'h0, 4'h9);
    rd(4'h0);
    wr(4'h1, 32'h8);
    idle(3);
    cyc(0, 1, 4'h0, 32'h0, '0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rd(4'h0);
    rd(4'h1);
    idle(2);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 9));
      d = $urandom;
      if (a == 4'h2) d = 32'($urandom_range(0, 12)) | (d & 32'hFFFF_0000);
      rst = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, d,
          ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0);
    end
    rst = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
